// File: rtl/round_constant_sequencer_if.sv
// round_constant_sequencer_if: beat handshake and state bus of the round constant sequencer.
// err_o exists only when ROUND_SEQ_ERR_FLAG_EN is defined.
interface round_constant_sequencer_if;
  logic             start_i;
  logic             mode_i;
  logic             valid_i;
  logic             ready_o;
  logic [4:0][63:0] state_i;
  logic             valid_o;
  logic             ready_i;
  logic [4:0][63:0] state_o;
  logic [3:0]       round_o;
  logic             last_o;
  logic             busy_o;
`ifdef ROUND_SEQ_ERR_FLAG_EN
  logic             err_o;
  modport slave (input start_i, mode_i, valid_i, state_i, ready_i,
                 output ready_o, valid_o, state_o, round_o, last_o, busy_o, err_o);
  modport master (output start_i, mode_i, valid_i, state_i, ready_i,
                  input ready_o, valid_o, state_o, round_o, last_o, busy_o, err_o);
`else
  modport slave (input start_i, mode_i, valid_i, state_i, ready_i,
                 output ready_o, valid_o, state_o, round_o, last_o, busy_o);
  modport master (output start_i, mode_i, valid_i, state_i, ready_i,
                  input ready_o, valid_o, state_o, round_o, last_o, busy_o);
`endif
endinterface

// File: rtl/round_constant_sequencer.sv
// round_constant_sequencer: XORs the Ascon round constant into x2 of each beat of a p^a/p^b permutation.
// Defining ROUND_SEQ_ERR_FLAG_EN adds err_o, pulsed on orphan beats and aborting restarts.
module round_constant_sequencer #(
  parameter int NB_ROUNDS_A = 12,
  parameter int NB_ROUNDS_B = 6
) (
  input logic                          clock_i,
  input logic                          reset_i,
  round_constant_sequencer_if.slave    bus
);
  if (NB_ROUNDS_A < 1 || NB_ROUNDS_A > 12 || NB_ROUNDS_B < 1 || NB_ROUNDS_B > 12) begin : g_bad_param
    $error("round_constant_sequencer: NB_ROUNDS_A/NB_ROUNDS_B must be in 1..12");
  end
  localparam logic [3:0] R0_A = 4'(12 - NB_ROUNDS_A);
  localparam logic [3:0] R0_B = 4'(12 - NB_ROUNDS_B);
  logic             valid_q, valid_d, last_q, last_d, busy_q, busy_d;
  logic [3:0]       round_q, round_d, cnt_q, cnt_d, r;
  logic [4:0][63:0] state_q, state_d;
  logic             acc, apply;
  assign bus.ready_o = !valid_q || bus.ready_i;
  assign acc         = bus.valid_i && bus.ready_o;
  // A start beat always wins, restarting even an in-flight permutation.
  always_comb begin
    r       = bus.start_i ? (bus.mode_i ? R0_B : R0_A) : cnt_q;
    apply   = bus.start_i || busy_q;
    valid_d = acc || (valid_q && !bus.ready_i);
    state_d = state_q;
    round_d = round_q;
    last_d  = last_q;
    busy_d  = busy_q;
    cnt_d   = cnt_q;
    if (acc) begin
      state_d          = bus.state_i;
      state_d[2][7:0]  = bus.state_i[2][7:0] ^ (apply ? {~r, r} : 8'h00);
      round_d          = apply ? r : 4'hF;
      last_d           = apply && r == 4'd11;
      busy_d           = apply && r != 4'd11;
      cnt_d            = busy_d ? r + 4'd1 : 4'd0;
    end
  end
  always_ff @(posedge clock_i or posedge reset_i)
    if (reset_i) begin
      valid_q <= 1'b0;
      state_q <= '0;
      round_q <= 4'hF;
      last_q  <= 1'b0;
      busy_q  <= 1'b0;
      cnt_q   <= 4'd0;
    end else begin
      valid_q <= valid_d;
      state_q <= state_d;
      round_q <= round_d;
      last_q  <= last_d;
      busy_q  <= busy_d;
      cnt_q   <= cnt_d;
    end
  assign bus.valid_o = valid_q;
  assign bus.state_o = state_q;
  assign bus.round_o = round_q;
  assign bus.last_o  = last_q;
  assign bus.busy_o  = busy_q;
`ifdef ROUND_SEQ_ERR_FLAG_EN
  logic err_q, err_d;
  // Error when start and busy agree: a restart mid-run, or a beat with no permutation.
  assign err_d = acc && (bus.start_i == busy_q);
  always_ff @(posedge clock_i or posedge reset_i)
    if (reset_i) err_q <= 1'b0;
    else         err_q <= err_d;
  assign bus.err_o = err_q;
`endif
endmodule
